// File: rtl/wb_uart_peripheral_bridge.sv
// wb_uart_peripheral_bridge
// 8-bit Wishbone slave front end for a 16550-style UART register file.
// All bus inputs are registered. A request seen in the registered stage
// produces a single-cycle write or read strobe toward the register file.
// A one-cycle ack follows, and the bridge then enforces a fixed dead
// time, so acks are never closer than 4 cycles apart.
module wb_uart_peripheral_bridge (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [7:0]  wb_dat8_i,
  input  logic [7:0]  wb_dat8_o,
  input  logic [31:0] wb_dat32_o,
  output logic [2:0]  wb_adr_int,
  output logic        we_o,
  output logic        re_o
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  // Registered bus inputs
  logic        we_q,  we_d;
  logic        stb_q, stb_d;
  logic        cyc_q, cyc_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  dat_o_q, dat_o_d;

  // Transfer FSM state
  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic        wre_q, wre_d;

  // Byte selects and the 32-bit debug bus have no effect in 8-bit mode
  logic        sel_unused_s;
  assign sel_unused_s = ^{sel_q, wb_dat32_o};

  // Next values of the input stage and the read-data register
  always_comb begin
    we_d    = wb_we_i;
    stb_d   = wb_stb_i;
    cyc_d   = wb_cyc_i;
    adr_d   = wb_adr_i;
    dat_d   = wb_dat_i;
    sel_d   = wb_sel_i;
    dat_o_d = wb_dat8_o;
  end

  // Input stage and read-data register, synchronous reset to zero
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'd0;
      sel_q   <= 4'd0;
      dat_o_q <= 8'd0;
    end else begin
      we_q    <= we_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      dat_o_q <= dat_o_d;
    end
  end

  // FSM state register with ack and strobe-enable flag
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q <= S0;
      ack_q   <= 1'b0;
      wre_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      wre_q   <= wre_d;
    end
  end

  // FSM next state: accept in S0, then walk S1..S3 as dead time.
  // wre re-arms on the S3->S0 return so a still-held request gets a fresh strobe.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    wre_d   = 1'b0;
    case (state_q)
      S0: begin
        if (stb_q && cyc_q) begin
          ack_d   = 1'b1;
          wre_d   = 1'b0;
          state_d = S1;
        end else begin
          ack_d   = 1'b0;
          wre_d   = 1'b1;
          state_d = S0;
        end
      end
      S1: begin
        state_d = S2;
      end
      S2: begin
        state_d = S3;
      end
      S3: begin
        state_d = S0;
        wre_d   = 1'b1;
      end
      default: begin
        state_d = S0;
        wre_d   = 1'b1;
      end
    endcase
  end

  // FSM outputs: single-cycle register strobes while armed
  always_comb begin
    we_o = we_q & stb_q & cyc_q & wre_q;
    re_o = ~we_q & stb_q & cyc_q & wre_q;
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_o_q;
  assign wb_adr_int = adr_q;
  assign wb_dat8_i  = dat_q;

endmodule

// File: tb/tb_wb_uart_peripheral_bridge.sv
// Self-checking bench for wb_uart_peripheral_bridge. A transaction-level
// model tracks the registered request and a dead-time countdown. It predicts
// strobes, ack and read data for directed scenarios and for random traffic.
module tb_wb_uart_peripheral_bridge;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [2:0]  wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic [7:0]  wb_dat8_i;
  logic [7:0]  wb_dat8_o;
  logic [31:0] wb_dat32_o;
  logic [2:0]  wb_adr_int;
  logic        we_o;
  logic        re_o;

  logic [7:0]  regfile [8];

  always #5 clk = ~clk;

  // The register file answers combinationally from the registered address
  assign wb_dat8_o = regfile[wb_adr_int];

  wb_uart_peripheral_bridge dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_we_i    (wb_we_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_sel_i   (wb_sel_i),
    .wb_ack_o   (wb_ack_o),
    .wb_dat8_i  (wb_dat8_i),
    .wb_dat8_o  (wb_dat8_o),
    .wb_dat32_o (wb_dat32_o),
    .wb_adr_int (wb_adr_int),
    .we_o       (we_o),
    .re_o       (re_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model: last captured request plus cycles left before accepting again
  logic       m_we, m_req, m_ack;
  logic [2:0] m_adr;
  logic [7:0] m_dat, m_dato;
  int         m_cool;
  logic       exp_we, exp_re;

  int strobe_q[$];
  int ack_q[$];
  logic [7:0] ack_data_q[$];

  // One clock: advance the model at the edge, then compare every output
  task automatic step();
    @(posedge clk);
    if (wb_rst_i) begin
      m_we = 1'b0; m_req = 1'b0; m_adr = 3'd0; m_dat = 8'd0;
      m_cool = 0; m_ack = 1'b0; m_dato = 8'd0;
    end else begin
      m_ack  = (m_cool == 0) && m_req;
      m_dato = regfile[m_adr];
      if (m_ack) m_cool = 3;
      else if (m_cool > 0) m_cool = m_cool - 1;
      m_we  = wb_we_i;
      m_req = wb_stb_i && wb_cyc_i;
      m_adr = wb_adr_i;
      m_dat = wb_dat_i;
    end
    cyc_no++;
    #1;
    exp_we = m_req && m_we && (m_cool == 0);
    exp_re = m_req && !m_we && (m_cool == 0);
    n_tests++;
    if (wb_ack_o !== m_ack) begin
      n_fail++; $display("FAIL ack cyc=%0d got=%b want=%b", cyc_no, wb_ack_o, m_ack);
    end
    n_tests++;
    if (we_o !== exp_we) begin
      n_fail++; $display("FAIL we_o cyc=%0d got=%b want=%b", cyc_no, we_o, exp_we);
    end
    n_tests++;
    if (re_o !== exp_re) begin
      n_fail++; $display("FAIL re_o cyc=%0d got=%b want=%b", cyc_no, re_o, exp_re);
    end
    n_tests++;
    if (wb_dat_o !== m_dato) begin
      n_fail++; $display("FAIL dat_o cyc=%0d got=%h want=%h", cyc_no, wb_dat_o, m_dato);
    end
    n_tests++;
    if (wb_adr_int !== m_adr) begin
      n_fail++; $display("FAIL adr_int cyc=%0d got=%h want=%h", cyc_no, wb_adr_int, m_adr);
    end
    n_tests++;
    if (wb_dat8_i !== m_dat) begin
      n_fail++; $display("FAIL dat8_i cyc=%0d got=%h want=%h", cyc_no, wb_dat8_i, m_dat);
    end
    if (we_o || re_o) strobe_q.push_back(cyc_no);
    if (wb_ack_o) begin
      ack_q.push_back(cyc_no);
      ack_data_q.push_back(wb_dat_o);
    end
    wb_sel_i   = 4'($urandom);
    wb_dat32_o = $urandom;
  endtask

  task automatic clear_logs();
    strobe_q.delete();
    ack_q.delete();
    ack_data_q.delete();
  endtask

  task automatic idle(input int n);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd6; wb_dat_i = 8'hA5;
    repeat (2) step();
    n_tests++;
    if ({wb_ack_o, we_o, re_o} !== 3'b000 || wb_dat_o !== 8'h00 || wb_adr_int !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got ack/we/re=%b%b%b dat_o=%h adr=%h want 000/00/0",
               wb_ack_o, we_o, re_o, wb_dat_o, wb_adr_int);
    end
    wb_rst_i = 1'b0;
    idle(4);
  endtask

  task automatic test_write();
    bit got = 1'b0;
    clear_logs();
    wb_adr_i = 3'd3; wb_dat_i = 8'h83; wb_we_i = 1'b1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (we_o) begin
        n_tests++;
        if (wb_adr_int !== 3'd3 || wb_dat8_i !== 8'h83) begin
          n_fail++;
          $display("FAIL write_regs got adr=%h dat=%h want 3/83", wb_adr_int, wb_dat8_i);
        end
      end
      if (wb_ack_o) got = 1'b1;
    end
    idle(5);
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL write_timeout got no ack want ack within 8 cycles");
    end
    n_tests++;
    if (strobe_q.size() != 1 || ack_q.size() != 1) begin
      n_fail++;
      $display("FAIL write_counts got strobes=%0d acks=%0d want 1/1", strobe_q.size(), ack_q.size());
    end else begin
      n_tests++;
      if (ack_q[0] - strobe_q[0] != 1) begin
        n_fail++; $display("FAIL write_ack_delay got %0d want 1", ack_q[0] - strobe_q[0]);
      end
    end
  endtask

  task automatic test_read();
    bit got = 1'b0;
    int n_re = 0;
    clear_logs();
    regfile[5] = 8'h60;
    wb_adr_i = 3'd5; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (re_o) n_re++;
      if (wb_ack_o) got = 1'b1;
    end
    idle(5);
    n_tests++;
    if (!got || n_re != 1) begin
      n_fail++; $display("FAIL read_handshake got ack=%b re_count=%0d want 1/1", got, n_re);
    end
    n_tests++;
    if (ack_data_q.size() != 1 || ack_data_q[0] !== 8'h60) begin
      n_fail++;
      $display("FAIL read_data got %h (acks=%0d) want 60",
               (ack_data_q.size() > 0) ? ack_data_q[0] : 8'hxx, ack_data_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit got = 1'b0;
    clear_logs();
    wb_adr_i = 3'($urandom); wb_dat_i = 8'($urandom); wb_we_i = 1'($urandom);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (wb_ack_o) got = 1'b1;
    end
    repeat (6) step();
    idle(8);
    n_tests++;
    if (strobe_q.size() != 2 || ack_q.size() != 2) begin
      n_fail++;
      $display("FAIL held_counts got strobes=%0d acks=%0d want 2/2", strobe_q.size(), ack_q.size());
    end else begin
      n_tests++;
      if (strobe_q[1] - strobe_q[0] != 4 || ack_q[1] - ack_q[0] != 4) begin
        n_fail++;
        $display("FAIL held_spacing got strobe_gap=%0d ack_gap=%0d want 4/4",
                 strobe_q[1] - strobe_q[0], ack_q[1] - ack_q[0]);
      end
    end
  endtask

  task automatic test_partial_handshake();
    clear_logs();
    wb_we_i = 1'($urandom); wb_adr_i = 3'($urandom);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b0;
    repeat (5) step();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b1;
    repeat (5) step();
    idle(2);
    n_tests++;
    if (strobe_q.size() != 0 || ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL partial_handshake got strobes=%0d acks=%0d want 0/0", strobe_q.size(), ack_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    clear_logs();
    wb_adr_i = 3'd2; wb_dat_i = 8'h5C; wb_we_i = 1'b1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (we_o) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL abort_timeout got no we_o want we_o within 8 cycles");
    end
    wb_rst_i = 1'b1;
    step();
    n_tests++;
    if ({wb_ack_o, we_o, re_o} !== 3'b000 || wb_dat_o !== 8'h00 || wb_adr_int !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_state got ack/we/re=%b%b%b dat_o=%h adr=%h want 000/00/0",
               wb_ack_o, we_o, re_o, wb_dat_o, wb_adr_int);
    end
    wb_rst_i = 1'b0;
    idle(5);
    n_tests++;
    if (ack_q.size() != 0) begin
      n_fail++; $display("FAIL abort_ack got acks=%0d want 0", ack_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      wb_rst_i = ($urandom_range(0, 49) == 0);
      wb_stb_i = ($urandom_range(0, 3) != 0);
      wb_cyc_i = ($urandom_range(0, 3) != 0);
      wb_we_i  = 1'($urandom);
      wb_adr_i = 3'($urandom);
      wb_dat_i = 8'($urandom);
      if ($urandom_range(0, 7) == 0) regfile[$urandom_range(0, 7)] = 8'($urandom);
      step();
    end
    wb_rst_i = 1'b0;
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regfile[i] = 8'($urandom);
    wb_rst_i = 1'b1; wb_adr_i = 3'd0; wb_dat_i = 8'd0; wb_we_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_sel_i = 4'd0; wb_dat32_o = 32'd0;
    m_we = 1'b0; m_req = 1'b0; m_adr = 3'd0; m_dat = 8'd0;
    m_cool = 0; m_ack = 1'b0; m_dato = 8'd0;
    #2;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_partial_handshake();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
